// File: rtl/buffer_pea_xbar.sv
// buffer_pea_xbar: registered crossbar/sequencer between the ping-pong activation buffers and the PE array,
// with per-layer drain and optional automatic ping-pong swap at each completed layer.
module buffer_pea_xbar #(
  parameter int N_BUF = 32,
  parameter int DATA_W = 16,
  parameter int N_ENG = 4,
  parameter int BUF_CTRL_W = 24,
  parameter int PEA_CTRL_W = 64,
  parameter logic [PEA_CTRL_W-1:0] PEA_CTRL_RST = '0,
  parameter int DRAIN_CYC = 3,
  localparam int EW = N_ENG > 1 ? $clog2(N_ENG) : 1
)(
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            cfg_valid,
  output logic                            cfg_ready,
  input  logic [EW-1:0]                   cfg_eng,
  input  logic [1:0]                      cfg_route,
  input  logic                            cfg_auto_swap,
  input  logic                            layer_done,
  input  logic                            abort,
  input  logic [N_ENG*BUF_CTRL_W-1:0]     eng_buf1_ctrl,
  input  logic [N_ENG*BUF_CTRL_W-1:0]     eng_buf2_ctrl,
  input  logic [N_ENG*PEA_CTRL_W-1:0]     eng_pea_ctrl,
  input  logic [(N_BUF+1)*DATA_W-1:0]     buf1_rd_data,
  input  logic [(N_BUF+1)*DATA_W-1:0]     buf2_rd_data,
  input  logic [(N_BUF+1)*DATA_W-1:0]     pea_out,
  output logic [BUF_CTRL_W-1:0]           buf1_ctrl,
  output logic [BUF_CTRL_W-1:0]           buf2_ctrl,
  output logic                            buf1_mode,
  output logic                            buf2_mode,
  output logic [N_BUF*DATA_W-1:0]         buf1_wr_data,
  output logic [N_BUF*DATA_W-1:0]         buf2_wr_data,
  output logic [PEA_CTRL_W-1:0]           pea_ctrl,
  output logic [N_BUF*DATA_W-1:0]         pea_in1,
  output logic [N_BUF*DATA_W-1:0]         pea_in2,
  output logic [1:0]                      state,
  output logic [1:0]                      cur_route,
  output logic [15:0]                     layer_cnt
);
  localparam logic [1:0] S_IDLE = 2'b00, S_ACTIVE = 2'b01, S_DRAIN = 2'b10;
  localparam int CW = $clog2(DRAIN_CYC + 1);
  logic [CW-1:0] cnt;
  logic [EW-1:0] eng;
  logic auto_swap, by_done, last, hs, ctl_on;
  logic [DATA_W-1:0] b1z, b2z, pz;
  logic [N_BUF*DATA_W-1:0] in1_d, in2_d, wr_d;
  assign last = state == S_DRAIN && cnt == CW'(1);
  assign cfg_ready = state == S_IDLE || last;
  assign hs = cfg_valid && cfg_ready;
  assign buf1_mode = state != S_IDLE;
  assign buf2_mode = state != S_IDLE;
  assign ctl_on = state == S_ACTIVE && eng != '0;
  assign b1z = buf1_rd_data[N_BUF*DATA_W +: DATA_W];
  assign b2z = buf2_rd_data[N_BUF*DATA_W +: DATA_W];
  assign pz = pea_out[N_BUF*DATA_W +: DATA_W];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      cnt <= '0;
      eng <= '0;
      auto_swap <= 1'b0;
      by_done <= 1'b0;
      cur_route <= 2'b01;
      layer_cnt <= '0;
    end else begin
      if (hs) begin
        eng <= cfg_eng;
        auto_swap <= cfg_auto_swap;
      end
      if (state == S_IDLE && hs) state <= S_ACTIVE;
      else if (state == S_ACTIVE && (layer_done || abort)) begin
        state <= S_DRAIN;
        cnt <= CW'(DRAIN_CYC);
        by_done <= ~abort;
      end else if (state == S_DRAIN) begin
        cnt <= cnt - CW'(1);
        if (last) state <= hs ? S_ACTIVE : S_IDLE;
      end else if (state == 2'b11) state <= S_IDLE;
      if (last && by_done) layer_cnt <= layer_cnt + 16'd1;
      // a freshly supplied route wins over the ping-pong toggle
      if (hs) cur_route <= cfg_route;
      else if (last && by_done && auto_swap) cur_route[0] <= ~cur_route[0];
    end
  end
  always_comb begin
    in1_d = '0;
    in2_d = '0;
    wr_d = '0;
    for (int i = 0; i < N_BUF; i++) begin
      in1_d[i*DATA_W +: DATA_W] = cur_route[0] ? buf1_rd_data[i*DATA_W +: DATA_W] : buf2_rd_data[i*DATA_W +: DATA_W];
      in2_d[i*DATA_W +: DATA_W] = cur_route == 2'b01 ? buf2_rd_data[i*DATA_W +: DATA_W] :
                                  cur_route == 2'b00 ? buf1_rd_data[i*DATA_W +: DATA_W] :
                                  cur_route == 2'b11 ? b1z : b2z;
      wr_d[i*DATA_W +: DATA_W] = cur_route[1] ? pz : pea_out[i*DATA_W +: DATA_W];
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf1_ctrl <= '0;
      buf2_ctrl <= '0;
      pea_ctrl <= PEA_CTRL_RST;
      pea_in1 <= '0;
      pea_in2 <= '0;
      buf1_wr_data <= '0;
      buf2_wr_data <= '0;
    end else begin
      buf1_ctrl <= ctl_on ? eng_buf1_ctrl[int'(eng)*BUF_CTRL_W +: BUF_CTRL_W] : '0;
      buf2_ctrl <= ctl_on ? eng_buf2_ctrl[int'(eng)*BUF_CTRL_W +: BUF_CTRL_W] : '0;
      pea_ctrl <= ctl_on ? eng_pea_ctrl[int'(eng)*PEA_CTRL_W +: PEA_CTRL_W] : PEA_CTRL_RST;
      pea_in1 <= in1_d;
      pea_in2 <= in2_d;
      buf1_wr_data <= wr_d;
      buf2_wr_data <= wr_d;
    end
  end
endmodule

// File: tb/tb_buffer_pea_xbar.sv
// tb_buffer_pea_xbar: directed checks of routing, control gating, drain sequencing and auto-swap.
module tb_buffer_pea_xbar;
  localparam int NB = 32, DW = 16;
  logic clk, rst_n, cfg_valid, cfg_ready, cfg_auto_swap, layer_done, abort;
  logic [1:0] cfg_eng, cfg_route, state, cur_route;
  logic [4*24-1:0] eng_buf1_ctrl, eng_buf2_ctrl;
  logic [4*64-1:0] eng_pea_ctrl;
  logic [(NB+1)*DW-1:0] buf1_rd_data, buf2_rd_data, pea_out;
  logic [23:0] buf1_ctrl, buf2_ctrl;
  logic buf1_mode, buf2_mode;
  logic [NB*DW-1:0] buf1_wr_data, buf2_wr_data, pea_in1, pea_in2;
  logic [63:0] pea_ctrl;
  logic [15:0] layer_cnt;
  logic [1:0] exp_route;
  int n_cmp = 0, n_bad = 0;
  buffer_pea_xbar dut (
    .clk(clk), .rst_n(rst_n), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_eng(cfg_eng), .cfg_route(cfg_route), .cfg_auto_swap(cfg_auto_swap),
    .layer_done(layer_done), .abort(abort),
    .eng_buf1_ctrl(eng_buf1_ctrl), .eng_buf2_ctrl(eng_buf2_ctrl), .eng_pea_ctrl(eng_pea_ctrl),
    .buf1_rd_data(buf1_rd_data), .buf2_rd_data(buf2_rd_data), .pea_out(pea_out),
    .buf1_ctrl(buf1_ctrl), .buf2_ctrl(buf2_ctrl), .buf1_mode(buf1_mode), .buf2_mode(buf2_mode),
    .buf1_wr_data(buf1_wr_data), .buf2_wr_data(buf2_wr_data), .pea_ctrl(pea_ctrl),
    .pea_in1(pea_in1), .pea_in2(pea_in2), .state(state), .cur_route(cur_route), .layer_cnt(layer_cnt)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  function automatic logic [15:0] ln(input logic [NB*DW-1:0] b, input int i);
    return b[i*DW +: DW];
  endfunction
  initial begin
    rst_n = 1'b0; cfg_valid = 1'b0; cfg_eng = 2'd0; cfg_route = 2'd0; cfg_auto_swap = 1'b0;
    layer_done = 1'b0; abort = 1'b0;
    eng_buf1_ctrl = {24'h1B0003, 24'h1B0002, 24'h1B0001, 24'h1B0000};
    eng_buf2_ctrl = {24'h2B0003, 24'h2B0002, 24'h2B0001, 24'h2B0000};
    eng_pea_ctrl = {64'hC3, 64'hC2, 64'hC1, 64'hC0};
    for (int i = 0; i <= NB; i++) begin
      buf1_rd_data[i*DW +: DW] = 16'h1000 + 16'(i);
      buf2_rd_data[i*DW +: DW] = 16'h2000 + 16'(i);
      pea_out[i*DW +: DW] = 16'h3000 + 16'(i);
    end
    step(); step();
    chk("rst_state", state, 0); chk("rst_route", cur_route, 1); chk("rst_cnt", layer_cnt, 0);
    chk("rst_ready", cfg_ready, 1); chk("rst_b1ctrl", buf1_ctrl, 0); chk("rst_pctrl", pea_ctrl, 0);
    chk("rst_mode", buf1_mode, 0); chk("rst_pin1", ln(pea_in1, 0), 0); chk("rst_wr1", ln(buf1_wr_data, 0), 0);
    rst_n = 1'b1; cfg_valid = 1'b1; cfg_eng = 2'd1; cfg_route = 2'b01;
    step();
    cfg_valid = 1'b0;
    chk("hs_state", state, 1); chk("hs_ready", cfg_ready, 0);
    buf1_rd_data[5*DW +: DW] = 16'hAAAA;
    step();
    chk("act_b1ctrl", buf1_ctrl, 24'h1B0001); chk("act_b2ctrl", buf2_ctrl, 24'h2B0001);
    chk("act_pctrl", pea_ctrl, 64'hC1); chk("act_mode", buf2_mode, 1);
    chk("act_pin1_5", ln(pea_in1, 5), 16'hAAAA); chk("act_pin2_5", ln(pea_in2, 5), 16'h2005);
    chk("act_wr1_5", ln(buf1_wr_data, 5), 16'h3005);
    buf1_rd_data[5*DW +: DW] = 16'hBBBB;
    chk("lat_hold", ln(pea_in1, 5), 16'hAAAA);
    step();
    chk("lat_new", ln(pea_in1, 5), 16'hBBBB);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("ab_state", state, 2); chk("ab_last_ctrl", buf1_ctrl, 24'h1B0001);
    step();
    chk("ab_q_b1", buf1_ctrl, 0); chk("ab_q_p", pea_ctrl, 0); chk("ab_mode", buf1_mode, 1); chk("ab_ready0", cfg_ready, 0);
    step();
    chk("ab_ready1", cfg_ready, 1); chk("ab_drain", state, 2);
    step();
    chk("ab_idle", state, 0); chk("ab_route", cur_route, 1); chk("ab_cnt", layer_cnt, 0);
    layer_done = 1'b1;
    step();
    layer_done = 1'b0;
    chk("ld_idle", state, 0); chk("ld_cnt", layer_cnt, 0);
    cfg_valid = 1'b1; cfg_eng = 2'd2; cfg_route = 2'b11;
    buf1_rd_data[NB*DW +: DW] = 16'h1234; pea_out[NB*DW +: DW] = 16'hBEEF;
    step();
    cfg_valid = 1'b0;
    chk("dn_state", state, 1); chk("dn_route", cur_route, 3);
    step();
    chk("dn_pin2_0", ln(pea_in2, 0), 16'h1234); chk("dn_pin2_31", ln(pea_in2, 31), 16'h1234);
    chk("dn_pin1_5", ln(pea_in1, 5), 16'hBBBB); chk("dn_wr2_0", ln(buf2_wr_data, 0), 16'hBEEF);
    chk("dn_wr2_31", ln(buf2_wr_data, 31), 16'hBEEF); chk("dn_wr1_7", ln(buf1_wr_data, 7), 16'hBEEF);
    chk("dn_b1ctrl", buf1_ctrl, 24'h1B0002); chk("dn_pctrl", pea_ctrl, 64'hC2);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_state", state, 0); chk("ar_pin2", ln(pea_in2, 0), 0); chk("ar_b1ctrl", buf1_ctrl, 0);
    chk("ar_pctrl", pea_ctrl, 0); chk("ar_route", cur_route, 1); chk("ar_ready", cfg_ready, 1); chk("ar_mode", buf1_mode, 0);
    step();
    rst_n = 1'b1; cfg_valid = 1'b1; cfg_eng = 2'd3; cfg_route = 2'b01; cfg_auto_swap = 1'b1;
    step();
    cfg_valid = 1'b0;
    chk("as_state", state, 1);
    step();
    chk("as_pctrl", pea_ctrl, 64'hC3);
    exp_route = 2'b01;
    for (int k = 0; k < 3; k++) begin
      exp_route[0] = ~exp_route[0];
      layer_done = 1'b1;
      step();
      layer_done = 1'b0;
      chk("as_drain", state, 2);
      step();
      chk("as_q_b1", buf1_ctrl, 0); chk("as_q_b2", buf2_ctrl, 0); chk("as_q_p", pea_ctrl, 0);
      step();
      chk("as_rdy", cfg_ready, 1);
      step();
      chk("as_idle", state, 0); chk("as_route", cur_route, exp_route); chk("as_cnt", layer_cnt, 64'(k + 1));
      if (k < 2) begin
        cfg_valid = 1'b1; cfg_route = exp_route;
        step();
        cfg_valid = 1'b0;
        step();
        chk("as_pin1_3", ln(pea_in1, 3), exp_route[0] ? 16'h1003 : 16'h2003);
      end
    end
    cfg_valid = 1'b1; cfg_eng = 2'd1; cfg_route = 2'b01;
    step();
    cfg_valid = 1'b0; layer_done = 1'b1;
    step();
    layer_done = 1'b0;
    step(); step();
    chk("bb_rdy", cfg_ready, 1); chk("bb_drain", state, 2);
    cfg_valid = 1'b1; cfg_eng = 2'd2; cfg_route = 2'b11;
    step();
    cfg_valid = 1'b0;
    chk("bb_state", state, 1); chk("bb_route", cur_route, 3); chk("bb_cnt", layer_cnt, 4);
    step();
    chk("bb_b1ctrl", buf1_ctrl, 24'h1B0002);
    abort = 1'b1;
    step();
    abort = 1'b0;
    step(); step(); step();
    chk("ab2_idle", state, 0); chk("ab2_cnt", layer_cnt, 4); chk("ab2_route", cur_route, 3);
    cfg_valid = 1'b1; cfg_eng = 2'd0; cfg_route = 2'b10;
    step();
    cfg_valid = 1'b0;
    step();
    chk("br_pin1_3", ln(pea_in1, 3), 16'h2003); chk("br_pin2_3", ln(pea_in2, 3), 16'h2020);
    chk("br_b1ctrl", buf1_ctrl, 0); chk("br_pctrl", pea_ctrl, 0); chk("br_mode", buf1_mode, 1);
    chk("br_wr1_0", ln(buf1_wr_data, 0), 16'hBEEF);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/buffer_pea_xbar.md
# buffer_pea_xbar

Parametrised, registered crossbar/sequencer between the two ping-pong activation buffers and the PE array. It selects one of N_ENG compute-engine controllers and one of four routing modes, then pipelines the data and control paths by one cycle. It drains in-flight traffic on every mode or layer change and optionally swaps ping-pong direction automatically at each layer boundary. It sits in the top level between the buffer pair, the PE array and the per-layer controllers.

## Interface
- N_BUF, 32: data lanes per buffer; lane N_BUF is the extra broadcast lane used by dense modes.
- DATA_W, 16: lane width.
- N_ENG, 4: engine count; engine 0 is IDLE (no controller), 1 = CONV, 2 = DENSE, 3 = POOL, further engines are generic.
- BUF_CTRL_W, 24: per-buffer control word width (r_en, w_en, addresses packed by the controller).
- PEA_CTRL_W, 64: PE array control word width.
- PEA_CTRL_RST, 0: PE control value driven while not ACTIVE (team default sets the dense_adder_reset bit).
- DRAIN_CYC, 3: quiet cycles inserted after each layer; must be ≥ 1.
- clk  in  1  clock.
- rst_n  in  1  asynchronous, active-low reset.
- cfg_valid / cfg_ready  in/out  1  configuration handshake.
- cfg_eng  in  $clog2(N_ENG)  engine select.
- cfg_route  in  2  01 AYBZ, 00 AZBY, 11 AYaZ, 10 BYbZ.
- cfg_auto_swap  in  1  toggle route[0] after each completed layer.
- layer_done  in  1  single-cycle pulse from the active controller.
- abort  in  1  abandon the layer immediately.
- eng_buf1_ctrl, eng_buf2_ctrl  in  N_ENG*BUF_CTRL_W  per-engine buffer controls.
- eng_pea_ctrl  in  N_ENG*PEA_CTRL_W  per-engine PE controls.
- buf1_rd_data, buf2_rd_data  in  (N_BUF+1)*DATA_W  buffer read buses.
- pea_out  in  (N_BUF+1)*DATA_W  PE array output bus.
- buf1_ctrl, buf2_ctrl  out  BUF_CTRL_W  registered buffer controls.
- buf1_mode, buf2_mode  out  1  1 while ACTIVE or DRAIN.
- buf1_wr_data, buf2_wr_data  out  N_BUF*DATA_W  registered write buses.
- pea_ctrl  out  PEA_CTRL_W  registered PE controls.
- pea_in1, pea_in2  out  N_BUF*DATA_W  registered PE inputs.
- state  out  2  00 IDLE, 01 ACTIVE, 10 DRAIN.
- cur_route  out  2  effective routing mode.
- layer_cnt  out  16  completed layers since reset; wraps.

## Operation
- FSM: IDLE, ACTIVE, DRAIN.
- cfg_ready = (state == IDLE) or (state == DRAIN and drain counter == 1).
- A handshake latches eng, route and auto_swap into the shadow registers.
- IDLE → ACTIVE on handshake.
- ACTIVE → DRAIN on layer_done or abort; the counter loads DRAIN_CYC.
- DRAIN decrements the counter each cycle. When it reaches 1:
  - with a handshake in the same cycle, go to ACTIVE with the new configuration (back-to-back layers, no IDLE cycle);
  - otherwise go to IDLE.
- On completion by layer_done, the exit from DRAIN:
  - increments layer_cnt;
  - if auto_swap is set, toggles route[0], so ping and pong exchange: AYBZ↔AZBY and AYaZ↔BYbZ.
  - A handshake that supplies a new route in the same cycle takes precedence over the toggle.
- Abort skips both the toggle and the increment.
- layer_done or abort outside ACTIVE is ignored. Both asserted together count as abort.
- Routing, registered, for i < N_BUF:
  - AYBZ: pea_in1[i] = buf1[i], pea_in2[i] = buf2[i].
  - AZBY: the same with buf1 and buf2 swapped.
  - AYaZ: pea_in1[i] = buf1[i], pea_in2[i] = buf1[N_BUF].
  - BYbZ: pea_in1[i] = buf2[i], pea_in2[i] = buf2[N_BUF].
  - Conv/pool modes: both buf*_wr_data[i] = pea_out[i].
  - Dense modes: every write lane = pea_out[N_BUF].
- Controls:
  - ACTIVE with eng ≠ 0: outputs = the selected engine's slice.
  - eng 0, DRAIN or IDLE: buffer controls = 0 and pea_ctrl = PEA_CTRL_RST.
- Data buses continue to pass through in every state.

## Timing
- Reset values:
  - state IDLE, cur_route 01, layer_cnt 0, shadow registers 0;
  - all ctrl outputs 0, pea_ctrl PEA_CTRL_RST, mode outputs 0;
  - all data outputs 0, cfg_ready 1.
- Handshake at edge t: state reads ACTIVE from t+1; the selected engine's control sampled at t+1 appears on the outputs at t+2.
- Data and control paths both have exactly 1-cycle latency and stay aligned.
- layer_done at edge t:
  - controls are quiet from t+2;
  - DRAIN spans DRAIN_CYC cycles;
  - the route toggle and layer_cnt update are visible at the cycle after DRAIN exits.
- rst_n assertion mid-layer clears everything immediately; no drain occurs.

## Test plan
- Reset, then handshake eng=1, route=01 → state ACTIVE the next cycle; buf1_ctrl equals the eng 1 slice one cycle after sampling; pea_in1[5] = buf1_rd_data[5] delayed by 1 cycle.
- Dense route 11, buf1 lane N_BUF = 0x1234 → every pea_in2 lane = 0x1234; pea_out[N_BUF] = 0xBEEF → every buf2_wr_data lane = 0xBEEF.
- auto_swap=1, route 01, three layer_done pulses each followed by DRAIN_CYC=3 → cur_route 00, 01, 00; layer_cnt 3; controls zero and pea_ctrl = PEA_CTRL_RST during each drain.
- Handshake presented during the final DRAIN cycle with route 11 → ACTIVE the next cycle with no IDLE cycle, cur_route 11 (toggle overridden).
- abort mid-layer → DRAIN, then IDLE; route unchanged, layer_cnt unchanged. layer_done asserted while IDLE → no effect.
- rst_n pulsed low mid-ACTIVE → all outputs at reset values asynchronously; next handshake proceeds normally.
